// File: rtl/bidir_buffer_ctrl.sv
// CE/SR sequencer for an 8-bit bidirectional buffer with turnaround dead time.
// Optional build macro BIDIR_CTRL_STATS_EN adds saturating TX/RX/turnaround counters.
module bidir_buffer_ctrl #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_REQ,
    input  logic [7:0] TX_DATA,
    input  logic       RX_REQ,
    input  logic [7:0] AOUT_IN,
    output logic       CE,
    output logic       SR,
    output logic [7:0] A_DRV,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       TX_DONE,
    output logic       BUSY
`ifdef BIDIR_CTRL_STATS_EN
    ,
    output logic [7:0] TX_COUNT,
    output logic [7:0] RX_COUNT,
    output logic [7:0] TURN_COUNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic       is_tx_q, is_tx_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sr_q, sr_d;
    logic       ce_q, ce_d;
    logic [7:0] a_drv_q, a_drv_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_done_q, tx_done_d;
    logic       busy_q, busy_d;
    logic       take_tx_s;

    // Arbitration: with both requests pending, the one matching DIR avoids a turnaround.
    always_comb begin
        take_tx_s = TX_REQ && (!RX_REQ || dir_q);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        is_tx_d   = is_tx_q;
        tx_byte_d = tx_byte_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        rx_data_d = rx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (TX_REQ || RX_REQ) begin
                    is_tx_d = take_tx_s;
                    cnt_d   = 4'd0;
                    if (take_tx_s) begin
                        tx_byte_d = TX_DATA;
                    end else begin
                        tx_byte_d = tx_byte_q;
                    end
                    if (take_tx_s != dir_q) begin
                        state_d = ST_TURN;
                        sr_d    = take_tx_s;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = ST_XFER;
                    cnt_d   = 4'd0;
                    dir_d   = is_tx_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_XFER: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    if (!is_tx_q) begin
                        rx_data_d = AOUT_IN;
                    end else begin
                        rx_data_d = rx_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are derived from the next state so they line up with it after the edge.
        ce_d       = (state_d == ST_XFER);
        if ((state_d == ST_XFER) && is_tx_d) begin
            a_drv_d = tx_byte_d;
        end else begin
            a_drv_d = 8'h00;
        end
        busy_d     = (state_d != ST_IDLE);
        tx_done_d  = (state_d == ST_DONE) && is_tx_q;
        rx_valid_d = (state_d == ST_DONE) && !is_tx_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            is_tx_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            cnt_q      <= 4'd0;
            sr_q       <= 1'b0;
            ce_q       <= 1'b0;
            a_drv_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            is_tx_q    <= is_tx_d;
            tx_byte_q  <= tx_byte_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ce_q       <= ce_d;
            a_drv_q    <= a_drv_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
        end
    end

    assign CE       = ce_q;
    assign SR       = sr_q;
    assign A_DRV    = a_drv_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign TX_DONE  = tx_done_q;
    assign BUSY     = busy_q;

`ifdef BIDIR_CTRL_STATS_EN
    logic [7:0] tx_count_q, tx_count_d;
    logic [7:0] rx_count_q, rx_count_d;
    logic [7:0] turn_count_q, turn_count_d;

    // Saturating event counters, updated on the same edge that raises the matching pulse.
    always_comb begin
        tx_count_d   = tx_count_q;
        rx_count_d   = rx_count_q;
        turn_count_d = turn_count_q;
        if (tx_done_d && (tx_count_q != 8'hFF)) begin
            tx_count_d = tx_count_q + 8'd1;
        end else begin
            tx_count_d = tx_count_q;
        end
        if (rx_valid_d && (rx_count_q != 8'hFF)) begin
            rx_count_d = rx_count_q + 8'd1;
        end else begin
            rx_count_d = rx_count_q;
        end
        if ((state_d == ST_TURN) && (state_q == ST_IDLE) && (turn_count_q != 8'hFF)) begin
            turn_count_d = turn_count_q + 8'd1;
        end else begin
            turn_count_d = turn_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_count_q   <= 8'h00;
            rx_count_q   <= 8'h00;
            turn_count_q <= 8'h00;
        end else begin
            tx_count_q   <= tx_count_d;
            rx_count_q   <= rx_count_d;
            turn_count_q <= turn_count_d;
        end
    end

    assign TX_COUNT   = tx_count_q;
    assign RX_COUNT   = rx_count_q;
    assign TURN_COUNT = turn_count_q;
`endif

endmodule

// File: tb/tb_bidir_buffer_ctrl.sv
// Directed self-checking bench for bidir_buffer_ctrl (TURN_CYC=2, HOLD_CYC=1).
module tb_bidir_buffer_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TX_REQ = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       RX_REQ = 1'b0;
    logic [7:0] AOUT_IN = 8'h00;
    logic       CE, SR, RX_VALID, TX_DONE, BUSY;
    logic [7:0] A_DRV, RX_DATA;
`ifdef BIDIR_CTRL_STATS_EN
    logic [7:0] TX_COUNT, RX_COUNT, TURN_COUNT;
`endif

    int n_vec = 0;
    int n_err = 0;

    bidir_buffer_ctrl #(.TURN_CYC(2), .HOLD_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .TX_REQ(TX_REQ), .TX_DATA(TX_DATA),
        .RX_REQ(RX_REQ), .AOUT_IN(AOUT_IN), .CE(CE), .SR(SR),
        .A_DRV(A_DRV), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DONE(TX_DONE), .BUSY(BUSY)
`ifdef BIDIR_CTRL_STATS_EN
        , .TX_COUNT(TX_COUNT), .RX_COUNT(RX_COUNT), .TURN_COUNT(TURN_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    logic [31:0] obs_s;
    assign obs_s = {11'd0, CE, SR, BUSY, TX_DONE, RX_VALID, A_DRV, RX_DATA};

    // Fields packed as {CE,SR,BUSY,TX_DONE,RX_VALID,A_DRV,RX_DATA}.
    function automatic logic [31:0] pk(input logic ce, input logic sr, input logic busy,
                                       input logic txd, input logic rxv,
                                       input logic [7:0] adrv, input logic [7:0] rxd);
        return {11'd0, ce, sr, busy, txd, rxv, adrv, rxd};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (CE,SR,BUSY,TXD,RXV,ADRV,RXD)", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp);
        @(posedge CLK);
        #1;
        check_val(tag, obs_s, exp);
    endtask

`ifdef BIDIR_CTRL_STATS_EN
    task automatic check_stats(input string tag, input logic [7:0] tx, input logic [7:0] rx,
                               input logic [7:0] tn);
        check_val({tag, "_txc"}, {24'd0, TX_COUNT}, {24'd0, tx});
        check_val({tag, "_rxc"}, {24'd0, RX_COUNT}, {24'd0, rx});
        check_val({tag, "_tnc"}, {24'd0, TURN_COUNT}, {24'd0, tn});
    endtask
`endif

    initial begin
        step("reset", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        RST = 1'b0;
        for (int i = 0; i < 10; i++) step("idle", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));

        // TX A5 from DIR=0: two turn cycles, one XFER, DONE.
        TX_REQ = 1'b1; TX_DATA = 8'hA5;
        step("tx1_turn0", pk(0, 1, 1, 0, 0, 8'h00, 8'h00));
        step("tx1_turn1", pk(0, 1, 1, 0, 0, 8'h00, 8'h00));
        step("tx1_xfer",  pk(1, 1, 1, 0, 0, 8'hA5, 8'h00));
        TX_DATA = 8'h3C;
        step("tx1_done",  pk(0, 1, 1, 1, 0, 8'h00, 8'h00));
        step("tx2_idle",  pk(0, 1, 0, 0, 0, 8'h00, 8'h00));
        step("tx2_xfer",  pk(1, 1, 1, 0, 0, 8'h3C, 8'h00));
        TX_REQ = 1'b0;
        step("tx2_done",  pk(0, 1, 1, 1, 0, 8'h00, 8'h00));

        // RX 5A after TX: turnaround back down.
        RX_REQ = 1'b1; AOUT_IN = 8'h5A;
        step("rx1_idle",  pk(0, 1, 0, 0, 0, 8'h00, 8'h00));
        step("rx1_turn0", pk(0, 0, 1, 0, 0, 8'h00, 8'h00));
        step("rx1_turn1", pk(0, 0, 1, 0, 0, 8'h00, 8'h00));
        step("rx1_xfer",  pk(1, 0, 1, 0, 0, 8'h00, 8'h00));
        RX_REQ = 1'b0;
        step("rx1_done",  pk(0, 0, 1, 0, 1, 8'h00, 8'h5A));
        step("rx1_hold",  pk(0, 0, 0, 0, 0, 8'h00, 8'h5A));
`ifdef BIDIR_CTRL_STATS_EN
        check_stats("seq", 8'd2, 8'd1, 8'd2);
`endif

        // Both requests with DIR=0: RX first without turnaround, then TX with one.
        TX_REQ = 1'b1; TX_DATA = 8'h96; RX_REQ = 1'b1; AOUT_IN = 8'hC3;
        step("both_rx_xfer",  pk(1, 0, 1, 0, 0, 8'h00, 8'h5A));
        RX_REQ = 1'b0;
        step("both_rx_done",  pk(0, 0, 1, 0, 1, 8'h00, 8'hC3));
        step("both_idle",     pk(0, 0, 0, 0, 0, 8'h00, 8'hC3));
        step("both_tx_turn0", pk(0, 1, 1, 0, 0, 8'h00, 8'hC3));
        step("both_tx_turn1", pk(0, 1, 1, 0, 0, 8'h00, 8'hC3));
        step("both_tx_xfer",  pk(1, 1, 1, 0, 0, 8'h96, 8'hC3));
        TX_REQ = 1'b0;
        step("both_tx_done",  pk(0, 1, 1, 1, 0, 8'h00, 8'hC3));
        step("both_end",      pk(0, 1, 0, 0, 0, 8'h00, 8'hC3));
`ifdef BIDIR_CTRL_STATS_EN
        check_stats("both", 8'd3, 8'd2, 8'd3);
`endif

        // Reset while in TURN.
        RX_REQ = 1'b1; AOUT_IN = 8'hEE;
        step("rt_turn0", pk(0, 0, 1, 0, 0, 8'h00, 8'hC3));
        RST = 1'b1; RX_REQ = 1'b0;
        step("rt_reset", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        RST = 1'b0;
        step("rt_after0", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        step("rt_after1", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
`ifdef BIDIR_CTRL_STATS_EN
        check_stats("rt", 8'd0, 8'd0, 8'd0);
`endif

        // Reset while in XFER.
        TX_REQ = 1'b1; TX_DATA = 8'h77;
        step("rx_turn0", pk(0, 1, 1, 0, 0, 8'h00, 8'h00));
        step("rx_turn1", pk(0, 1, 1, 0, 0, 8'h00, 8'h00));
        step("rx_xfer",  pk(1, 1, 1, 0, 0, 8'h77, 8'h00));
        RST = 1'b1; TX_REQ = 1'b0;
        step("rx_reset", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        RST = 1'b0;
        step("rx_after0", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        step("rx_after1", pk(0, 0, 0, 0, 0, 8'h00, 8'h00));

        // DIR was reset to down: RX goes straight to XFER.
        RX_REQ = 1'b1; AOUT_IN = 8'h11;
        step("dir_rx_xfer", pk(1, 0, 1, 0, 0, 8'h00, 8'h00));
        RX_REQ = 1'b0;
        step("dir_rx_done", pk(0, 0, 1, 0, 1, 8'h00, 8'h11));
        step("dir_rx_idle", pk(0, 0, 0, 0, 0, 8'h00, 8'h11));
`ifdef BIDIR_CTRL_STATS_EN
        check_stats("end", 8'd0, 8'd1, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bidir_buffer_ctrl.md
Name: bidir_buffer_ctrl

Overview:
- Synchronous controller that drives the CE/SR pins of the 8-bit bidirectional buffer. It sequences byte transfers in both directions: up (A→B, transmit) and down (B→A, receive).
- Presents TX/RX request handshakes to the local logic.
- Inserts a bus turnaround dead time, with CE low, whenever the direction changes, so the two buffer directions are never enabled together.

Parameters:
- TURN_CYC, 2, dead-time cycles with CE=0 before the first transfer in a new direction; legal 1..15
- HOLD_CYC, 1, cycles CE stays high per transfer; legal 1..15

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- TX_REQ  input  1  request to send TX_DATA up through the buffer
- TX_DATA  input  8  byte to send; sampled when the request is accepted
- RX_REQ  input  1  request to receive one byte from the buffer's B side
- AOUT_IN  input  8  buffer AOUT bus (B→A data)
- CE  output  1  buffer chip enable
- SR  output  1  buffer direction: 1 = up (A→B), 0 = down (B→A)
- A_DRV  output  8  data presented on buffer A input
- RX_DATA  output  8  last received byte
- RX_VALID  output  1  one-cycle pulse when RX_DATA is updated
- TX_DONE  output  1  one-cycle pulse when a transmit completes
- BUSY  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (RST=1 at a clock edge): CE=0, SR=0, A_DRV=8'h00, RX_DATA=8'h00, RX_VALID=0, TX_DONE=0, BUSY=0. State=IDLE, direction register DIR=0 (down), counters=0.
- Reset mid-operation: abort immediately to the reset values. No TX_DONE or RX_VALID pulse is produced for the aborted transfer.
- States: IDLE, TURN, XFER, DONE.
- IDLE:
  - CE=0, BUSY=0. Requests are level-sampled only in IDLE.
  - If both requests are high, the request matching the current DIR wins (avoids a turnaround).
  - On accept: latch TX_DATA (if TX) and set target direction T (1 for TX, 0 for RX).
  - If T≠DIR: go to TURN and set SR=T on the same edge.
  - If T=DIR: go straight to XFER.
- TURN:
  - CE=0; SR already holds the new direction. Stay TURN_CYC cycles, then go to XFER; DIR updates to T.
- XFER:
  - CE=1 for exactly HOLD_CYC cycles.
  - TX: A_DRV = latched byte for the duration of XFER.
  - RX: A_DRV=8'h00; AOUT_IN is registered into RX_DATA on the edge that ends the last XFER cycle.
  - Then go to DONE.
- DONE:
  - One cycle. CE=0, A_DRV=8'h00, BUSY=1.
  - TX_DONE=1 for a transmit; RX_VALID=1 for a receive.
  - Next state IDLE.
- Requester handshake: deassert REQ in the DONE cycle. A REQ still high in IDLE starts a new transfer.
- SR changes only in the cycle CE goes 0→TURN or while in reset, never while CE=1.
- Latency, request accepted at edge t, no turnaround: CE high for cycles t+1..t+HOLD_CYC; DONE/VALID at cycle t+HOLD_CYC+1.
- Latency with turnaround: add TURN_CYC cycles before XFER.
- RX_DATA holds its value until the next receive completes.
- A_DRV is 8'h00 whenever CE=0.
- BUSY stays high from the cycle after accept through DONE inclusive.

Optional Feature:
- Macro: BIDIR_CTRL_STATS_EN.
- When defined, adds output ports TX_COUNT[7:0], RX_COUNT[7:0] and TURN_COUNT[7:0]. These are saturating counters (stop at 8'hFF) that increment on TX_DONE, RX_VALID and on each TURN entry respectively. All three reset to 0.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle → CE=0, SR=0, BUSY=0, A_DRV=00, RX_DATA=00 for 10 cycles with no requests.
- TX_REQ=1, TX_DATA=8'hA5, TURN_CYC=2, HOLD_CYC=1, from reset (DIR=0):
  - SR=1 at t+1; CE=0 for 2 cycles; CE=1, A_DRV=A5 for 1 cycle; TX_DONE pulse one cycle later.
- Second TX of 8'h3C immediately after → no TURN; CE=1 at t+1; TX_DONE at t+2.
- RX_REQ after TX, bench drives AOUT_IN=8'h5A:
  - SR 1→0 while CE=0; after 2 turn cycles CE=1, SR=0; RX_DATA=5A with RX_VALID pulse.
- TX_REQ and RX_REQ both high with DIR=0 → RX served first, no turnaround; TX served afterwards, with turnaround.
- RST asserted during TURN and during XFER → next cycle all outputs at reset values, no TX_DONE/RX_VALID.
- With BIDIR_CTRL_STATS_EN, run the full sequence → TX_COUNT=2, RX_COUNT=1, TURN_COUNT=2.
